// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counter table indexed by PC,
// plus execute-side branch resolution, registered redirect and perf counters.
module branch_predictor #(
  parameter int         AWIDTH      = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_STATE  = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] fetch_pc_i,
  output logic              pred_taken_o,
  input  logic              ex_valid_i,
  input  logic [6:0]        ex_opcode_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [AWIDTH-1:0] ex_pc_i,
  input  logic [AWIDTH-1:0] ex_target_i,
  input  logic              ex_pred_taken_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  output logic              ex_taken_o,
  output logic              mispredict_o,
  output logic [AWIDTH-1:0] redirect_pc_o,
  output logic [31:0]       branch_cnt_o,
  output logic [31:0]       mispredict_cnt_o
);

  localparam int         IDXW       = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [1:0]        bht_d [BHT_ENTRIES];
  logic              mispredict_q, mispredict_d;
  logic [AWIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]       branch_cnt_q, branch_cnt_d;
  logic [31:0]       mispredict_cnt_q, mispredict_cnt_d;

  logic [IDXW-1:0]   fetch_idx;
  logic [IDXW-1:0]   ex_idx;
  logic              is_br;
  logic              f3_ok;
  logic              taken_raw;
  logic [1:0]        ex_ctr;
  logic              unused_fetch_bits;

  assign fetch_idx    = fetch_pc_i[IDXW+1:2];
  assign ex_idx       = ex_pc_i[IDXW+1:2];
  // Fetch reads the registered table only, so an update in flight is not bypassed.
  assign pred_taken_o = bht_q[fetch_idx][1];

  assign unused_fetch_bits = ^{fetch_pc_i[AWIDTH-1:IDXW+2], fetch_pc_i[1:0]};

  always_comb begin
    f3_ok     = 1'b0;
    taken_raw = 1'b0;
    case (ex_funct3_i)
      3'b000: begin f3_ok = 1'b1; taken_raw = breq_i;  end
      3'b001: begin f3_ok = 1'b1; taken_raw = ~breq_i; end
      3'b100,
      3'b110: begin f3_ok = 1'b1; taken_raw = brlt_i;  end
      3'b101,
      3'b111: begin f3_ok = 1'b1; taken_raw = ~brlt_i; end
      default: begin f3_ok = 1'b0; taken_raw = 1'b0;   end
    endcase
    is_br      = ex_valid_i && (ex_opcode_i == OPC_BRANCH) && f3_ok;
    ex_taken_o = is_br && taken_raw;
  end

  always_comb begin
    bht_d  = bht_q;
    ex_ctr = bht_q[ex_idx];
    if (is_br) begin
      if (ex_taken_o) begin
        if (ex_ctr != 2'b11) bht_d[ex_idx] = ex_ctr + 2'd1;
      end else begin
        if (ex_ctr != 2'b00) bht_d[ex_idx] = ex_ctr - 2'd1;
      end
    end
  end

  always_comb begin
    mispredict_d     = is_br && (ex_taken_o != ex_pred_taken_i);
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (mispredict_d) begin
      redirect_pc_d = ex_taken_o ? ex_target_i : (ex_pc_i + AWIDTH'(4));
    end
    if (is_br && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict_d && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= INIT_STATE;
      end
      mispredict_q     <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      bht_q            <= bht_d;
      mispredict_q     <= mispredict_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign mispredict_o     = mispredict_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch predictor and resolution unit for the pd3 RISC-V core.
- Fetch side: returns a taken/not-taken prediction for the fetch PC from a table of 2-bit saturating counters.
- Execute side: consumes the breq/brlt flags produced by branch_control, the branch opcode and funct3, and decides the actual branch outcome.
- It then updates the table and issues a registered mispredict/redirect to fetch, plus performance counters.

Parameters:
- AWIDTH, 32, PC and target width.
- BHT_ENTRIES, 64, number of counters; must be a power of 2; IDXW = log2(BHT_ENTRIES).
- INIT_STATE, 2'b01, counter value loaded at reset (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets all state.
- fetch_pc_i  in  AWIDTH  PC being fetched.
- pred_taken_o  out  1  combinational prediction = bht[idx(fetch_pc_i)][1].
- ex_valid_i  in  1  execute-stage instruction valid.
- ex_opcode_i  in  7  execute-stage opcode.
- ex_funct3_i  in  3  execute-stage funct3.
- ex_pc_i  in  AWIDTH  PC of the execute-stage instruction.
- ex_target_i  in  AWIDTH  computed branch target (pc + imm).
- ex_pred_taken_i  in  1  prediction that was carried down the pipe with this instruction.
- breq_i  in  1  rs1 == rs2, from branch_control.
- brlt_i  in  1  rs1 < rs2 (signed for funct3 1xx with bit1=0, unsigned for bit1=1), from branch_control.
- ex_taken_o  out  1  combinational actual outcome.
- mispredict_o  out  1  registered, one-cycle pulse.
- redirect_pc_o  out  AWIDTH  registered correct next PC, valid while mispredict_o=1.
- branch_cnt_o  out  32  resolved conditional branches.
- mispredict_cnt_o  out  32  mispredicted branches.

Behaviour:
- Index: idx(pc) = pc[IDXW+1:2]. pc[1:0] and upper bits are ignored, so aliasing is permitted.
- Valid branch: is_br = ex_valid_i & ex_opcode_i==7'b1100011 & funct3 in {000,001,100,101,110,111}.
- Outcome funct3 mapping:
  - 000 (BEQ): breq_i
  - 001 (BNE): ~breq_i
  - 100 (BLT) / 110 (BLTU): brlt_i
  - 101 (BGE) / 111 (BGEU): ~brlt_i
- When is_br=0: ex_taken_o=0, no table update, no counter change, no mispredict.
- Table update (when is_br=1), at the clock edge, counter at idx(ex_pc_i):
  - taken: +1, saturating at 11.
  - not taken: -1, saturating at 00.
- Simultaneous fetch read and update of the same index: pred_taken_o shows the pre-update value that cycle; no bypass. The new value is visible the next cycle.
- Mispredict (when is_br=1 and ex_taken_o != ex_pred_taken_i), registered, latency 1 cycle:
  - next cycle mispredict_o=1.
  - redirect_pc_o = ex_target_i if taken, else ex_pc_i+4 (mod 2^AWIDTH).
  - Otherwise next cycle mispredict_o=0 and redirect_pc_o holds its last value.
- Counters (increment after the edge, saturate at 32'hFFFFFFFF, never wrap):
  - branch_cnt_o +1 per is_br.
  - mispredict_cnt_o +1 per mispredict.
- Reset (rst=0 at an edge):
  - every counter entry = INIT_STATE.
  - mispredict_o=0, redirect_pc_o=0, branch_cnt_o=0, mispredict_cnt_o=0.
  - Reset wins over a concurrent update; a pending mispredict pulse is dropped.
  - Reset may be asserted mid-operation; state is fully reinitialised within that one edge.

Test Plan:
- Reset: hold rst=0 one edge, release; fetch_pc_i=0x104 -> pred_taken_o=0, mispredict_o=0, both counters 0.
- BEQ taken, mispredicted: ex_pc=0x104, target=0x200, breq=1, pred=0 -> ex_taken_o=1 comb; next cycle mispredict_o=1, redirect_pc_o=0x200, branch_cnt=1, mispredict_cnt=1; entry1 01->10, fetch 0x104 now predicts 1; cycle after, mispredict_o=0.
- BNE not taken, mispredicted: ex_pc=0x104, breq=1, pred=1 -> redirect_pc_o=0x108, mispredict_o=1 for one cycle; entry1 10->01.
- Saturation and hysteresis: three BLTU (funct3=110), brlt=1, at pc 0x104 -> entry reaches 11 and stays 11. One BGEU (funct3=111), brlt=1 (not taken) -> 10, pred_taken_o still 1. Aliased fetch 0x204 also predicts 1.
- Non-branches: opcode 1100011 with funct3=010, and opcode 0110011 with ex_valid_i=1, mismatching pred -> no mispredict, counters unchanged, table unchanged. ex_valid_i=0 with a valid branch -> same.
- Same-index collision and mid-op reset:
  - fetch 0x104 and a taken update at 0x104 in one cycle -> pred_taken_o shows the old value that cycle, the new value the next cycle.
  - rst=0 on the edge where a mispredict would register -> mispredict_o=0, counters 0, entry1 back to 01.
